aesl_proc_deadlock_detect: RTL
==============================

Name: aesl_proc_deadlock_detect

Overview:
Per-process deadlock detector for the C/RTL cosim testbench. One instance sits beside each dataflow process and feeds bit PROC_ID of the report unit's `dl_in_vec`. Its jobs:
- measure how long its process has been stalled on other processes;
- raise the initial deadlock flag;
- take part in the one-hop-per-cycle token walk that the report unit uses to print each dependence cycle.

Parameters:
PROC_NUM, 4, number of dataflow processes; width of all vectors.
PROC_ID, 0, index of the monitored process (0..PROC_NUM-1).
STALL_CYCLES, 1000, consecutive stalled cycles (>=1) before the process counts as blocked.

Ports:
reset  in  1  asynchronous, active-low reset.
clock  in  1  clock.
dep_vec  in  PROC_NUM  bit j=1: the process is stalled this cycle on a channel or sync shared with process j. Bit PROC_ID is ignored.
blocked_vec  in  PROC_NUM  `blocked` outputs of all detector instances. Bit PROC_ID is ignored.
token_in_vec  in  PROC_NUM  bit j=1: instance j passes the token to this process. Bit PROC_ID is ignored.
origin  in  PROC_NUM  one-hot cycle start from the report unit; valid for one cycle.
token_clear  in  1  report unit ends the current cycle walk.
dl_detect_in  in  1  report unit has latched a deadlock; suppresses further initial flags.
blocked  out  1  process is blocked.
dl_out  out  1  deadlock / token-hit indication to report unit bit PROC_ID.
token_out_vec  out  PROC_NUM  one-hot token forward to the selected dependency.

Behaviour:
Definitions:
- self = 1<<PROC_ID.
- stall = |(dep_vec & ~self).
- cand = dep_vec & blocked_vec & ~self.
- dep_sel = one-hot of the lowest set bit of cand, or 0 if none.

Stall counter cnt:
- Width $clog2(STALL_CYCLES+1); reset 0.
- If stall: saturating increment. If not stall: cleared to 0.

FSM states: RUN, STALL, BLOCKED, TOKEN. Reset state RUN.
- RUN -> STALL when stall.
- STALL -> RUN when !stall.
- STALL -> BLOCKED when stall and cnt == STALL_CYCLES-1. With STALL_CYCLES=1, RUN goes directly to BLOCKED.
- BLOCKED -> RUN when !stall.
- BLOCKED -> TOKEN on take, where take = stall & !visited & (origin[PROC_ID] | token_hit).
- TOKEN -> BLOCKED after exactly one cycle (RUN if !stall).

Outputs and flags:
- blocked = (state==BLOCKED | state==TOKEN). Reset 0.
- token_hit = (state==BLOCKED | state==TOKEN) & |(token_in_vec & ~self).
- local_dl = state==BLOCKED & ((dep_vec & ~blocked_vec & ~self)==0) & !dl_detect_in & !reported.
- dl_out = local_dl | token_hit. Combinational. Reset 0.
- reported: set when local_dl=1; cleared when state returns to RUN. Result: local_dl is a single-cycle pulse per blocking episode.
- origin[PROC_ID] alone never drives dl_out. The report unit ignores it while in its detect state.

Token register:
- token_out_vec is registered, reset 0.
- On the edge entering TOKEN, load dep_sel as sampled at that edge.
- On every other edge, load 0.
- Result: the token is visible for exactly one cycle, and forward latency is 1 cycle (arrival cycle t -> token_out_vec in t+1).

visited flag:
- Set on entry to TOKEN.
- Cleared by token_clear, and on RUN.
- A token arriving while visited still raises dl_out (cycle closure) but is not re-forwarded. This prevents an endless walk.

token_clear:
- Zeroes token_out_vec at the next edge.
- Forces TOKEN -> BLOCKED.
- Clears visited.
- Has no effect on cnt or reported.

Simultaneous events:
- !stall beats take: state -> RUN, token dropped, token_out_vec 0.
- token_clear beats take in the same cycle.
- origin and token_hit in the same cycle: a single take.

Reset:
- Asserting reset mid-operation clears cnt, state, reported, visited and token_out_vec immediately, independent of the clock.
- blocked and dl_out go to 0 combinationally.

Test Plan:
1. STALL_CYCLES=4, PROC_ID=1, dep_vec=0b0100 for 3 cycles, then 0 -> blocked stays 0; cnt returns to 0; dl_out never 1.
2. As in 1, but dep_vec=0b0100 held and blocked_vec=0b0100 -> blocked=1 from stall cycle 5; dl_out=1 for exactly one cycle; no second pulse while held.
3. As in 2, with dl_detect_in=1 before blocking -> blocked=1; dl_out stays 0.
4. Blocked, dep_vec=0b0101, blocked_vec=0b0101, origin=0b0010 in cycle t -> dl_out 0 in t; token_out_vec=0b0001 in t+1 only; 0 from t+2.
5. Blocked, token_in_vec=0b1000 in cycle t -> dl_out=1 in t; token_out_vec=dep_sel in t+1. Second arrival without token_clear -> dl_out=1, token_out_vec stays 0. After token_clear, a third arrival is forwarded again.
6. Reset driven low while in TOKEN with token_out_vec=0b0100 -> token_out_vec=0, blocked=0, dl_out=0 before the next clock edge. After release, the state is RUN.

Source files
------------

// File: rtl/aesl_proc_deadlock_detect.sv
// rtl/aesl_proc_deadlock_detect.sv - per-process stall timer, deadlock flag and cycle-walk token hop
module aesl_proc_deadlock_detect #(
  parameter int PROC_NUM     = 4,
  parameter int PROC_ID      = 0,
  parameter int STALL_CYCLES = 1000
) (
  input  logic                reset,
  input  logic                clock,
  input  logic [PROC_NUM-1:0] dep_vec,
  input  logic [PROC_NUM-1:0] blocked_vec,
  input  logic [PROC_NUM-1:0] token_in_vec,
  input  logic [PROC_NUM-1:0] origin,
  input  logic                token_clear,
  input  logic                dl_detect_in,
  output logic                blocked,
  output logic                dl_out,
  output logic [PROC_NUM-1:0] token_out_vec
);

  localparam int CW = $clog2(STALL_CYCLES + 1);
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(STALL_CYCLES - 1);
  localparam logic [PROC_NUM-1:0] LP_SELF = PROC_NUM'(1) << PROC_ID;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    BLOCKED = 2'd2,
    TOKEN   = 2'd3
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_reported;
  logic                r_visited;
  logic [PROC_NUM-1:0] r_token_out;

  logic [PROC_NUM-1:0] w_dep_other;
  logic [PROC_NUM-1:0] w_cand;
  logic [PROC_NUM-1:0] w_dep_sel;
  logic [PROC_NUM-1:0] w_unblocked_dep;
  logic                w_stall;
  logic                w_in_blocked;
  logic                w_token_hit;
  logic                w_local_dl;
  logic                w_take;
  logic                w_cnt_last;

  assign w_dep_other     = dep_vec & ~LP_SELF;
  assign w_stall         = |w_dep_other;
  assign w_cand          = w_dep_other & blocked_vec;
  // Two's-complement trick isolates the lowest set bit of the candidate set.
  assign w_dep_sel       = w_cand & (~w_cand + PROC_NUM'(1));
  assign w_unblocked_dep = w_dep_other & ~blocked_vec;
  assign w_cnt_last      = (r_cnt == LP_CNT_LAST);

  assign w_in_blocked = (r_state == BLOCKED) || (r_state == TOKEN);
  assign w_token_hit  = w_in_blocked && (|(token_in_vec & ~LP_SELF));
  assign w_local_dl   = (r_state == BLOCKED) && (w_unblocked_dep == '0) &&
                        !dl_detect_in && !r_reported;
  // token_clear in the same cycle suppresses the take; !stall is handled by the FSM order.
  assign w_take       = w_stall && !r_visited && (origin[PROC_ID] || w_token_hit) &&
                        !token_clear;

  assign blocked       = w_in_blocked;
  assign dl_out        = w_local_dl || w_token_hit;
  assign token_out_vec = r_token_out;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_reported  <= 1'b0;
      r_visited   <= 1'b0;
      r_token_out <= '0;
    end else begin
      r_token_out <= '0;

      if (!w_stall) begin
        r_cnt <= '0;
      end else if (r_cnt != {CW{1'b1}}) begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_local_dl) begin
        r_reported <= 1'b1;
      end
      if (token_clear) begin
        r_visited <= 1'b0;
      end

      case (r_state)
        RUN: begin
          if (w_stall) begin
            r_state <= w_cnt_last ? BLOCKED : STALL;
          end
        end
        STALL: begin
          if (!w_stall) begin
            r_state <= RUN;
          end else if (w_cnt_last) begin
            r_state <= BLOCKED;
          end
        end
        BLOCKED: begin
          if (!w_stall) begin
            r_state <= RUN;
          end else if (w_take) begin
            r_state     <= TOKEN;
            r_token_out <= w_dep_sel;
            r_visited   <= 1'b1;
          end
        end
        TOKEN: begin
          r_state <= w_stall ? BLOCKED : RUN;
        end
        default: r_state <= RUN;
      endcase

      // Every state falls back to RUN when the stall ends, closing the blocking episode.
      if (!w_stall) begin
        r_reported <= 1'b0;
        r_visited  <= 1'b0;
      end
    end
  end

endmodule
